// File: rtl/lbm_timestep_sequencer.sv
// Purpose: sequences NUM_PHASES start/done phases per LBM time step, counts completed steps, pulses snapshot/run-done.
// Latency: all outputs registered; a step with immediate phase completion takes 2*NUM_PHASES+1 cycles.
// Backpressure: Enable=0 holds before the next Phase_start; an in-flight phase always completes; Abort returns to idle.
module lbm_timestep_sequencer #(
    parameter int MAX_TIME         = 8,
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
    parameter int NUM_PHASES       = 3,
    parameter int PHASE_W          = $clog2(NUM_PHASES),
    parameter int SNAP_INTERVAL    = 0
) (
    input  logic                        Clk_i,
    input  logic                        Reset_i,
    input  logic                        Enable_i,
    input  logic                        Start_i,
    input  logic                        Abort_i,
    input  logic [TIME_COUNT_WIDTH:0]   Num_steps_i,
    input  logic [NUM_PHASES-1:0]       Phase_done_i,
    output logic [NUM_PHASES-1:0]       Phase_start_o,
    output logic [PHASE_W-1:0]          Phase_idx_o,
    output logic [TIME_COUNT_WIDTH:0]   Data_out_o,
    output logic                        Busy_o,
    output logic                        Run_done_o,
    output logic                        Snapshot_o
);

    localparam int CW = TIME_COUNT_WIDTH + 1;
    localparam int SW = (SNAP_INTERVAL > 1) ? $clog2(SNAP_INTERVAL + 1) : 1;
    localparam logic [CW-1:0]         MAX_C   = CW'(MAX_TIME);
    localparam logic [PHASE_W-1:0]    LAST_PH = PHASE_W'(NUM_PHASES - 1);
    localparam logic [SW-1:0]         SNAP_C  = SW'(SNAP_INTERVAL);
    localparam logic [NUM_PHASES-1:0] ONE_PH  = NUM_PHASES'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           limit_q, limit_d;
    logic [CW-1:0]           data_q, data_d;
    logic [CW-1:0]           data_inc;
    logic [PHASE_W-1:0]      idx_q, idx_d;
    logic [SW-1:0]           snap_q, snap_d;
    logic [SW-1:0]           snap_rem;
    logic [NUM_PHASES-1:0]   start_q, start_d;
    logic                    busy_q;
    logic                    done_q, done_d;
    logic                    snapo_q, snapo_d;

    // Next-state and registered-output decode; Abort overrides everything at the end.
    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        data_d   = data_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        start_d  = '0;
        done_d   = 1'b0;
        snapo_d  = 1'b0;
        data_inc = data_q + CW'(1);
        // snap_q==0 means a full interval is still outstanding
        snap_rem = (snap_q == '0) ? SNAP_C : snap_q;

        case (state_q)
            S_IDLE: begin
                if (Start_i) begin
                    limit_d = ((Num_steps_i == '0) || (Num_steps_i > MAX_C)) ? MAX_C : Num_steps_i;
                    data_d  = '0;
                    idx_d   = '0;
                    snap_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (Enable_i) begin
                    start_d = ONE_PH << idx_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The cycle the start pulse is visible is not a valid done cycle.
                if ((start_q == '0) && Phase_done_i[idx_q]) begin
                    if (idx_q != LAST_PH) begin
                        // Issue the next phase straight away when allowed so a phase costs two cycles.
                        idx_d   = idx_q + PHASE_W'(1);
                        start_d = Enable_i ? (ONE_PH << idx_d) : '0;
                        state_d = Enable_i ? S_WAIT : S_ISSUE;
                    end else begin
                        state_d = S_ADVANCE;
                    end
                end
            end
            S_ADVANCE: begin
                data_d = data_inc;
                if (SNAP_INTERVAL != 0) begin
                    if (snap_rem == SW'(1)) begin
                        snapo_d = 1'b1;
                        snap_d  = '0;
                    end else begin
                        snap_d  = snap_rem - SW'(1);
                    end
                end
                if (data_inc == limit_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = '0;
                    start_d = Enable_i ? ONE_PH : '0;
                    state_d = Enable_i ? S_WAIT : S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (Abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            limit_d = limit_q;
            data_d  = data_q;
            idx_d   = idx_q;
            snap_d  = snap_q;
            start_d = '0;
            done_d  = 1'b0;
            snapo_d = 1'b0;
        end
    end

    // State and output registers with immediate reset.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= S_IDLE;
            limit_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            snapo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            start_q <= start_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            snapo_q <= snapo_d;
        end
    end

    assign Phase_start_o = start_q;
    assign Phase_idx_o   = idx_q;
    assign Data_out_o    = data_q;
    assign Busy_o        = busy_q;
    assign Run_done_o    = done_q;
    assign Snapshot_o    = snapo_q;

endmodule

// File: tb/tb_lbm_timestep_sequencer.sv
module tb_lbm_timestep_sequencer;

    localparam int NP = 3;
    localparam int CW = 4;

    logic          Clk, Reset, Enable, Start, Abort;
    logic [CW-1:0] Num_steps;
    logic [NP-1:0] Phase_done, Phase_start;
    logic [1:0]    Phase_idx;
    logic [CW-1:0] Data_out;
    logic          Busy, Run_done, Snapshot;

    lbm_timestep_sequencer #(
        .MAX_TIME(8),
        .NUM_PHASES(3),
        .SNAP_INTERVAL(2)
    ) dut (
        .Clk_i(Clk),
        .Reset_i(Reset),
        .Enable_i(Enable),
        .Start_i(Start),
        .Abort_i(Abort),
        .Num_steps_i(Num_steps),
        .Phase_done_i(Phase_done),
        .Phase_start_o(Phase_start),
        .Phase_idx_o(Phase_idx),
        .Data_out_o(Data_out),
        .Busy_o(Busy),
        .Run_done_o(Run_done),
        .Snapshot_o(Snapshot)
    );

    typedef struct {
        int p;
        int d;
    } start_t;

    start_t q_start[$];
    int     q_done[$];
    int     q_snap[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int eng_lat  = 1;
    bit noise_en = 0;
    int exp_gap  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Phase engines: answer each start pulse eng_lat cycles later; optional
    // noise drives every done bit except the one of the phase last started.
    initial begin
        logic [NP-1:0] last, pend;
        int cnt;
        last = '0; pend = '0; cnt = 0;
        Phase_done = '0;
        forever begin
            @(posedge Clk);
            #1;
            Phase_done = '0;
            if (Phase_start != '0) begin
                last = Phase_start;
                pend = Phase_start;
                cnt  = eng_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) Phase_done = pend;
            end
            if (noise_en) Phase_done = Phase_done | ~last;
        end
    end

    // Monitor: pops expected events whenever the DUT presents one.
    initial begin
        int last_p0;
        start_t e;
        logic [NP-1:0] ev;
        last_p0 = 0;
        forever begin
            @(negedge Clk);
            if (Phase_start != '0) begin
                if (q_start.size() == 0) begin
                    check("unexpected_phase_start", int'(Phase_start), 0);
                end else begin
                    e  = q_start.pop_front();
                    ev = NP'(1) << e.p;
                    check("phase_start_vec", int'(Phase_start), int'(ev));
                    check("phase_idx_at_start", int'(Phase_idx), e.p);
                    check("data_at_start", int'(Data_out), e.d);
                end
                if (Phase_start == 3'b001) begin
                    if (Data_out != '0 && exp_gap != 0)
                        check("step_period", cyc - last_p0, exp_gap);
                    last_p0 = cyc;
                end
            end
            if (Run_done) begin
                if (q_done.size() == 0) check("unexpected_run_done", int'(Run_done), 0);
                else check("run_done_count", int'(Data_out), q_done.pop_front());
            end
            if (Snapshot) begin
                if (q_snap.size() == 0) check("unexpected_snapshot", int'(Snapshot), 0);
                else check("snapshot_count", int'(Data_out), q_snap.pop_front());
            end
        end
    end

    task automatic push_run(input int steps);
        for (int s = 0; s < steps; s++)
            for (int p = 0; p < NP; p++) q_start.push_back('{p, s});
        for (int s = 1; s <= steps; s++)
            if (s % 2 == 0) q_snap.push_back(s);
        q_done.push_back(steps);
    endtask

    task automatic do_start(input int num);
        @(negedge Clk);
        Num_steps = CW'(num);
        Start = 1;
        @(negedge Clk);
        Start = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (Busy && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("run_ends_within_budget", int'(Busy), 0);
    endtask

    task automatic wait_pulse(input int p, input int d, input int budget);
        int  n = 0;
        bit  found = 0;
        logic [NP-1:0] want;
        want = NP'(1) << p;
        while (!found && n < budget) begin
            if (Phase_start == want && Data_out == CW'(d)) found = 1;
            else begin
                @(negedge Clk);
                n++;
            end
        end
        check("awaited_pulse_seen", int'(found), 1);
    endtask

    task automatic check_drained(input string name);
        check(name, q_start.size() + q_done.size() + q_snap.size(), 0);
    endtask

    initial begin
        Reset = 0; Enable = 1; Start = 0; Abort = 0; Num_steps = '0;
        #1 Reset = 1;
        repeat (2) @(negedge Clk);
        check("rst_phase_start", int'(Phase_start), 0);
        check("rst_phase_idx", int'(Phase_idx), 0);
        check("rst_data_out", int'(Data_out), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_run_done", int'(Run_done), 0);
        check("rst_snapshot", int'(Snapshot), 0);
        Reset = 0;

        // Num_steps=0 -> full 8-step run, 7 cycles per step
        exp_gap = 7;
        push_run(8);
        do_start(0);
        wait_idle(200);
        check("final_count_default", int'(Data_out), 8);
        check_drained("drained_default_run");

        // Over-range request clamps to 8
        push_run(8);
        do_start(12);
        wait_idle(200);
        check("final_count_clamped", int'(Data_out), 8);
        check_drained("drained_clamped_run");

        // Three steps: one snapshot at step 2
        push_run(3);
        do_start(3);
        wait_idle(200);
        check("final_count_three", int'(Data_out), 3);
        check_drained("drained_three_run");

        // Asynchronous reset between edges in the middle of a wait
        for (int p = 0; p < NP; p++) q_start.push_back('{p, 0});
        q_start.push_back('{0, 1});
        q_start.push_back('{1, 1});
        do_start(5);
        wait_pulse(1, 1, 50);
        @(posedge Clk);
        #2 Reset = 1;
        #1;
        check("async_rst_busy", int'(Busy), 0);
        check("async_rst_data", int'(Data_out), 0);
        check("async_rst_idx", int'(Phase_idx), 0);
        check("async_rst_start", int'(Phase_start), 0);
        @(negedge Clk);
        Reset = 0;
        repeat (4) @(negedge Clk);
        check("post_rst_idle", int'(Busy), 0);
        check("post_rst_data", int'(Data_out), 0);
        check_drained("drained_reset_run");

        // Enable dropped during phase 1: phase 1 completes, then holds
        exp_gap = 0;
        push_run(1);
        do_start(1);
        wait_pulse(1, 0, 50);
        Enable = 0;
        repeat (6) begin
            @(negedge Clk);
            check("paused_no_start", int'(Phase_start), 0);
        end
        check("paused_idx", int'(Phase_idx), 2);
        check("paused_data", int'(Data_out), 0);
        check("paused_busy", int'(Busy), 1);
        Enable = 1;
        wait_idle(100);
        check_drained("drained_pause_run");

        // Abort during step 4
        exp_gap = 7;
        for (int s = 0; s < 3; s++)
            for (int p = 0; p < NP; p++) q_start.push_back('{p, s});
        q_start.push_back('{0, 3});
        q_start.push_back('{1, 3});
        q_snap.push_back(2);
        do_start(0);
        wait_pulse(1, 3, 100);
        Abort = 1;
        @(negedge Clk);
        Abort = 0;
        check("abort_busy", int'(Busy), 0);
        check("abort_data_hold", int'(Data_out), 3);
        repeat (5) @(negedge Clk);
        check("abort_data_still", int'(Data_out), 3);
        check_drained("drained_abort_run");
        push_run(1);
        do_start(1);
        check("restart_clears_data", int'(Data_out), 0);
        wait_idle(100);
        check_drained("drained_after_abort");

        // Start while busy and wrong-phase done bits are both ignored
        eng_lat  = 3;
        noise_en = 1;
        exp_gap  = 13;
        push_run(2);
        do_start(2);
        repeat (4) begin
            @(negedge Clk);
            Num_steps = CW'(5);
            Start = 1;
            @(negedge Clk);
            Start = 0;
        end
        wait_idle(200);
        check("final_count_noisy", int'(Data_out), 2);
        check_drained("drained_noisy_run");
        noise_en = 0;
        eng_lat  = 1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
